led_frame_scanner: RTL
======================

// Module: led_frame_scanner
// PURPOSE
//  Feeds led_array_driver. Holds the displayed N×N frame in a tear-free double buffer.
//  Sequences the column index x, and gates the driver enable with dwell and blanking timing.
//  Upstream logic (e.g. game-of-life core) pushes whole frames via valid/ready.
//  Downstream, cells/x/ena connect directly to led_array_driver.
// PARAMETERS
//  N                 5     grid edge; frame is N*N bits, x counts 0..N-1
//  TICKS_PER_COLUMN  1000  clk cycles ena is held high per column (>=1)
//  BLANK_TICKS       2     clk cycles ena is low before each column (>=1; used only with macro)
// PORTS
//  clk          in   1               system clock, all state on rising edge
//  rst          in   1               synchronous, active-high reset
//  run          in   1               1 = scan, 0 = return to IDLE
//  frame_in     in   N*N             new frame, bit N*j+i = LED (i,j)
//  frame_valid  in   1               frame_in valid
//  frame_ready  out  1               scanner can accept a frame
//  cells        out  N*N             displayed frame -> led_array_driver.cells
//  x            out  $clog2(N)+1     active column -> led_array_driver.x
//  ena          out  1               drive enable -> led_array_driver.ena
//  frame_done   out  1               1-cycle pulse when column N-1 dwell completes
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; cells=0, x=0, ena=0, frame_done=0, pending empty.
//   frame_ready=1 on the first cycle after reset.
//  Buffers: one pending register plus the displayed register (cells).
//   frame_ready = !pending_full.
//   Transfer occurs on frame_valid & frame_ready; pending becomes full next cycle.
//   frame_valid while not ready: no transfer. frame_in must be held stable by upstream.
//  FSM: IDLE -> BLANK -> DWELL -> (BLANK | IDLE). All outputs registered.
//   IDLE:  ena=0, x=0, tick counter=0. On run=1: copy pending to cells if full
//          (pending is emptied), then go to BLANK.
//   BLANK: ena=0 for BLANK_TICKS cycles, then DWELL.
//   DWELL: ena=1 for exactly TICKS_PER_COLUMN cycles. On the last tick:
//          x<N-1: x<=x+1, go to BLANK.
//          x==N-1: x<=0, frame_done=1 for one cycle, go to BLANK (frame boundary).
//  Frame boundary: cells<=pending if pending full, and pending is cleared.
//   If a transfer occurs on the boundary cycle with pending empty,
//   frame_in goes directly to cells, and pending stays empty.
//   cells never changes at any other time while run=1 (no tearing).
//  Column period = TICKS_PER_COLUMN+BLANK_TICKS; frame period = N*(that).
//  run=0 in any state: next cycle is IDLE, ena=0, x=0, counters cleared.
//   cells holds its value; pending is kept; no frame_done pulse.
//  rst mid-scan: same as the reset values above; any pending frame is discarded.
//  Counters are sized with $clog2(max+1) and never exceed their terminal count.
//   x never reaches N.
// CONFIGURATION
//  LED_SCAN_BLANKING_EN defined: the BLANK state is used as described above
//   (anti-ghosting gap between columns).
//  LED_SCAN_BLANKING_EN undefined: the BLANK state is removed.
//   The FSM goes IDLE->DWELL and DWELL->DWELL, and ena stays 1 continuously while running.
//   Column period = TICKS_PER_COLUMN. BLANK_TICKS is ignored.
// TESTING (N=3, TICKS_PER_COLUMN=4, BLANK_TICKS=1 unless noted)
//  1 Reset: rst high 2 cycles, run=0 -> cells=0, x=0, ena=0, frame_done=0; frame_ready=1 after.
//  2 Push 9'h1FF, then run=1 -> cells=9'h1FF before first ena=1.
//    Pattern is ena 0,1,1,1,1 per column; x steps 0,1,2,0.
//    frame_done pulses every 15 cycles.
//  3 Mid-frame push 9'h001 while x=1 -> frame_ready drops next cycle; cells stays 9'h1FF until x wraps.
//    Then cells=9'h001 and frame_ready=1.
//  4 Push on the exact boundary cycle with pending empty -> cells updates that edge.
//    frame_ready never drops.
//  5 run=0 while x=2 in DWELL -> next cycle ena=0, x=0, no frame_done pulse.
//    run=1 again -> restart at column 0.
//  6 Macro undefined -> ena held 1 while running; x advances every 4 cycles.
//    frame_done every 12 cycles.

Source files
------------

// File: rtl/led_frame_scanner.sv
// Column scanner for led_array_driver: tear-free double-buffered N*N frame, column
// sequencing and dwell/blank enable timing. Optional blanking gap: LED_SCAN_BLANKING_EN.
module led_frame_scanner #(
  parameter int N                = 5,
  parameter int TICKS_PER_COLUMN = 1000,
  parameter int BLANK_TICKS      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [N*N-1:0]       frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [N*N-1:0]       cells,
  output logic [$clog2(N):0]   x,
  output logic                 ena,
  output logic                 frame_done,
  output logic [1:0]           dbg_state
);

  // Handshake: a frame transfers on a rising edge where frame_valid && frame_ready;
  // frame_in must stay stable while frame_valid is high and frame_ready is low.

  localparam int XW      = $clog2(N) + 1;
  localparam int CNT_TOP = (TICKS_PER_COLUMN > BLANK_TICKS) ? TICKS_PER_COLUMN : BLANK_TICKS;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(TICKS_PER_COLUMN - 1);
`ifdef LED_SCAN_BLANKING_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1
`ifdef LED_SCAN_BLANKING_EN
    ,
    BLANK = 2'd2
`endif
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N*N-1:0]  pending;
  logic            pending_full;

  logic            take;
  logic            col_end;
  logic            boundary;
  logic            load_pending;
  logic            load_direct;

  assign frame_ready = ~pending_full;
  assign dbg_state   = state;

  assign take     = frame_valid & ~pending_full;
  assign col_end  = (state == DWELL) && (cnt == DWELL_LAST);
  assign boundary = run && col_end && (x == X_LAST);

  // cells only changes at scan start or at a frame boundary, never mid-frame
  assign load_pending = run && pending_full && ((state == IDLE) || boundary);
  assign load_direct  = boundary && take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      x            <= '0;
      ena          <= 1'b0;
      frame_done   <= 1'b0;
      cells        <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (load_pending) begin
        cells        <= pending;
        pending_full <= 1'b0;
      end else if (load_direct) begin
        cells <= frame_in;
      end else if (take) begin
        pending      <= frame_in;
        pending_full <= 1'b1;
      end

      if (!run) begin
        state <= IDLE;
        cnt   <= '0;
        x     <= '0;
        ena   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            x   <= '0;
`ifdef LED_SCAN_BLANKING_EN
            state <= BLANK;
            ena   <= 1'b0;
`else
            state <= DWELL;
            ena   <= 1'b1;
`endif
          end
`ifdef LED_SCAN_BLANKING_EN
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              cnt   <= '0;
              state <= DWELL;
              ena   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          DWELL: begin
            if (col_end) begin
              cnt <= '0;
              if (x == X_LAST) begin
                x          <= '0;
                frame_done <= 1'b1;
              end else begin
                x <= x + 1'b1;
              end
`ifdef LED_SCAN_BLANKING_EN
              state <= BLANK;
              ena   <= 1'b0;
`else
              state <= DWELL;
              ena   <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            x     <= '0;
            ena   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
